// File: rtl/judge_3.sv
// judge_3: registered three-input majority voter.
// Samples votes a/b/c on enabled clock edges and registers the verdict,
// the vote tally, a unanimity flag, a one-hot dissenter marker and a
// saturating count of passing decisions. Every output is a flop output,
// so nothing passes combinationally from the inputs to the outputs.
module judge_3 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             out,
  output logic [1:0]       votes,
  output logic             unanimous,
  output logic [2:0]       dissent,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam int NUM_VOTERS = 3;

  // Voters packed as {A, B, C} so that bit 2 = A, bit 1 = B, bit 0 = C.
  logic [NUM_VOTERS-1:0] vote_w;
  assign vote_w = {a, b, c};

  logic             out_q,       out_d;
  logic [1:0]       votes_q,     votes_d;
  logic             unanimous_q, unanimous_d;
  logic [2:0]       dissent_q,   dissent_d;
  logic [CNT_W-1:0] pass_cnt_q,  pass_cnt_d;

  // Verdict computed from the live votes; only used when the edge is enabled.
  logic                  maj_w;
  logic [1:0]            tally_w;
  logic                  unan_w;
  logic [NUM_VOTERS-1:0] dis_w;
  logic                  cnt_sat_w;

  assign maj_w     = (a & b) | (a & c) | (b & c);
  assign tally_w   = {1'b0, a} + {1'b0, b} + {1'b0, c};
  assign unan_w    = (a == b) & (b == c);
  // The counter freezes at all-ones instead of wrapping back to zero.
  assign cnt_sat_w = &pass_cnt_q;

  // A voter dissents when its vote differs from the majority; with three
  // voters at most one can disagree, so this is one-hot or all-zero.
  for (genvar gi = 0; gi < NUM_VOTERS; gi++) begin : g_dissent
    assign dis_w[gi] = vote_w[gi] ^ maj_w;
  end

  // Next-state selection: hold everything unless the sample is enabled.
  always_comb begin
    out_d       = out_q;
    votes_d     = votes_q;
    unanimous_d = unanimous_q;
    dissent_d   = dissent_q;
    pass_cnt_d  = pass_cnt_q;
    if (en) begin
      out_d       = maj_w;
      votes_d     = tally_w;
      unanimous_d = unan_w;
      dissent_d   = dis_w;
      if (maj_w && !cnt_sat_w) begin
        pass_cnt_d = pass_cnt_q + 1'b1;
      end
    end
  end

  // Output registers with synchronous active-low clear; reset beats enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= 1'b0;
      votes_q     <= 2'd0;
      unanimous_q <= 1'b0;
      dissent_q   <= 3'b000;
      pass_cnt_q  <= '0;
    end else begin
      out_q       <= out_d;
      votes_q     <= votes_d;
      unanimous_q <= unanimous_d;
      dissent_q   <= dissent_d;
      pass_cnt_q  <= pass_cnt_d;
    end
  end

  assign out       = out_q;
  assign votes     = votes_q;
  assign unanimous = unanimous_q;
  assign dissent   = dissent_q;
  assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_judge_3.sv
// Directed bench for judge_3: one instance at the default counter width and
// one at CNT_W = 4 share the same stimulus.
module tb_judge_3;

  logic       clk = 1'b0;
  logic       rst_n, en, a, b, c;
  logic       out8, out4, un8, un4;
  logic [1:0] votes8, votes4;
  logic [2:0] dis8, dis4;
  logic [7:0] cnt8;
  logic [3:0] cnt4;

  int errors = 0;
  int checks = 0;

  // Expected {out, votes, unanimous, dissent} for abc = 0..7, hand-derived.
  localparam logic [6:0] SWEEP_EXP [8] = '{
    7'b0_00_1_000, 7'b0_01_0_001, 7'b0_01_0_010, 7'b1_10_0_100,
    7'b0_01_0_100, 7'b1_10_0_010, 7'b1_10_0_001, 7'b1_11_1_000};
  // Running pass count after each sweep step.
  localparam int SWEEP_CNT [8] = '{0, 0, 0, 1, 1, 2, 3, 4};

  logic [6:0] obs8, obs4;
  assign obs8 = {out8, votes8, un8, dis8};
  assign obs4 = {out4, votes4, un4, dis4};

  judge_3 #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
    .out(out8), .votes(votes8), .unanimous(un8), .dissent(dis8),
    .pass_cnt(cnt8));

  judge_3 #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
    .out(out4), .votes(votes4), .unanimous(un4), .dissent(dis4),
    .pass_cnt(cnt4));

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; {a, b, c} = 3'b111;
    tick(); tick();
    checks++;
    if (obs8 !== 7'b0 || cnt8 !== 8'd0) begin
      errors++;
      $display("FAIL reset_w8: got obs=%b cnt=%0d, want obs=0000000 cnt=0", obs8, cnt8);
    end
    checks++;
    if (obs4 !== 7'b0 || cnt4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_w4: got obs=%b cnt=%0d, want obs=0000000 cnt=0", obs4, cnt4);
    end
  endtask

  task automatic test_sweep();
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a, b, c} = v;
      tick();
      checks++;
      if (obs8 !== SWEEP_EXP[i]) begin
        errors++;
        $display("FAIL sweep abc=%b: got {out,votes,un,dis}=%b, want %b", v, obs8, SWEEP_EXP[i]);
      end
      checks++;
      if (cnt8 !== 8'(SWEEP_CNT[i]) || cnt4 !== 4'(SWEEP_CNT[i])) begin
        errors++;
        $display("FAIL sweep_cnt abc=%b: got cnt8=%0d cnt4=%0d, want %0d", v, cnt8, cnt4, SWEEP_CNT[i]);
      end
    end
  endtask

  task automatic test_hold();
    en = 1'b0; {a, b, c} = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs8 !== 7'b1_11_1_000 || cnt8 !== 8'd4 || cnt4 !== 4'd4) begin
        errors++;
        $display("FAIL hold cycle %0d: got obs=%b cnt8=%0d cnt4=%0d, want obs=1111000 cnt=4",
                 i, obs8, cnt8, cnt4);
      end
    end
  endtask

  task automatic test_saturation();
    rst_n = 1'b0; en = 1'b1; {a, b, c} = 3'b110;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (cnt4 !== 4'((k > 15) ? 15 : k) || cnt8 !== 8'(k)) begin
        errors++;
        $display("FAIL saturate step %0d: got cnt4=%0d cnt8=%0d, want cnt4=%0d cnt8=%0d",
                 k, cnt4, cnt8, (k > 15) ? 15 : k, k);
      end
      checks++;
      if (obs4 !== 7'b1_10_0_001) begin
        errors++;
        $display("FAIL saturate_out step %0d: got obs=%b, want 1100001", k, obs4);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; en = 1'b1; {a, b, c} = 3'b111;
    tick();
    checks++;
    if (obs4 !== 7'b0 || cnt4 !== 4'd0 || obs8 !== 7'b0 || cnt8 !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: got obs4=%b cnt4=%0d obs8=%b cnt8=%0d, want all zero",
               obs4, cnt4, obs8, cnt8);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs4 !== 7'b1_11_1_000 || cnt4 !== 4'd1 || cnt8 !== 8'd1) begin
      errors++;
      $display("FAIL reset_release: got obs4=%b cnt4=%0d cnt8=%0d, want obs=1111000 cnt=1",
               obs4, cnt4, cnt8);
    end
  endtask

  task automatic test_sync_reset();
    en = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    checks++;
    if (obs8 !== 7'b1_11_1_000 || cnt8 !== 8'd1) begin
      errors++;
      $display("FAIL sync_reset_mid: got obs=%b cnt=%0d, want obs=1111000 cnt=1", obs8, cnt8);
    end
    tick();
    checks++;
    if (obs8 !== 7'b1_11_1_000 || cnt8 !== 8'd1 || cnt4 !== 4'd1) begin
      errors++;
      $display("FAIL sync_reset_edge: got obs=%b cnt8=%0d cnt4=%0d, want obs=1111000 cnt=1",
               obs8, cnt8, cnt4);
    end
  endtask

  task automatic test_glitch();
    en = 1'b1;
    {a, b, c} = 3'b000; #1;
    {a, b, c} = 3'b101; #1;
    {a, b, c} = 3'b010; #1;
    {a, b, c} = 3'b111; #1;
    {a, b, c} = 3'b011;
    checks++;
    if (obs8 !== 7'b1_11_1_000) begin
      errors++;
      $display("FAIL no_comb_path: got obs=%b before edge, want 1111000", obs8);
    end
    tick();
    checks++;
    if (obs8 !== 7'b1_10_0_100 || cnt8 !== 8'd2) begin
      errors++;
      $display("FAIL glitch: got obs=%b cnt=%0d, want obs=1100100 cnt=2", obs8, cnt8);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    test_reset();
    test_sweep();
    test_hold();
    test_saturation();
    test_reset_mid();
    test_sync_reset();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/judge_3.md
Name: judge_3

Overview:
- Three-input majority voter ("judge") that decides pass/fail from three independent 1-bit votes a, b, c.
- Registered: all outputs update on the clock edge following the sampled votes.
- Also provides a vote tally, a unanimity flag, a one-hot marker for the dissenting voter, and a saturating counter of passed decisions.
- Sits as a small decision leaf under control logic that presents votes and consumes the verdict.

Parameters:
- CNT_W, 8, width of the pass_cnt saturating counter (legal range 1..32).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  input  1  vote-sample enable; when 0, all outputs hold.
- a  input  1  vote of judge A (1 = pass).
- b  input  1  vote of judge B.
- c  input  1  vote of judge C.
- out  output  1  majority verdict: 1 when at least two of a, b, c are 1.
- votes  output  2  number of 1 votes, 0..3.
- unanimous  output  1  1 when votes == 0 or votes == 3.
- dissent  output  3  one-hot minority voter, bit2 = A, bit1 = B, bit0 = C; 000 when unanimous.
- pass_cnt  output  CNT_W  saturating count of sampled cycles with a pass verdict.

Behaviour:
- Reset: on a rising edge with rst_n == 0, all outputs clear regardless of en.
  - out = 0, votes = 0, unanimous = 0, dissent = 000, pass_cnt = 0.
- Normal operation: on a rising edge with rst_n == 1 and en == 1, sample a, b, c and register:
  - out <= (a&b) | (a&c) | (b&c)
  - votes <= a + b + c, zero-extended to 2 bits
  - unanimous <= (a==b) & (b==c)
  - dissent <= {a^maj, b^maj, c^maj}, where maj is the new out value.
    - Exactly one bit is set when not unanimous; all bits are 0 when unanimous.
  - pass_cnt <= pass_cnt + 1 if maj == 1 and pass_cnt != all-ones; otherwise it holds.
- Hold: when en == 0 and rst_n == 1, every output keeps its value.
- Latency: exactly 1 clock from sampled inputs to outputs. No combinational path from inputs to outputs.
- Input changes between edges have no effect; only values present at the edge matter.
- Counter saturation: at all-ones (e.g. 255 for CNT_W = 8), further passes leave the counter at all-ones. It never wraps to 0.
- Reset mid-operation: reset wins over en and clears the counter even when saturated.
  - The first enabled edge after reset release samples fresh votes normally.
- Truth table for out, listed as abc -> out: 000->0, 001->0, 010->0, 011->1, 100->0, 101->1, 110->1, 111->1.
- No X propagation requirements beyond standard synthesizable RTL. Outputs are defined from the first reset edge onward.

Test Plan:
- Reset then exhaustive sweep:
  - Stimulus: rst_n = 0 for 2 edges; release with en = 1; drive abc 000, 001, 010, 011, 100, 101, 110, 111, one per clock.
  - Required: one edge later, out = 0,0,0,1,0,1,1,1 and votes = 0,1,1,2,1,2,2,3.
  - Required: unanimous = 1 only for 000 and 111.
  - Required: dissent = 000, 001, 010, 100, 100, 010, 001, 000.
  - Required: pass_cnt ends at 4.
- Enable hold:
  - Stimulus: after abc = 111 sampled, set en = 0 and drive abc = 000 for 5 clocks.
  - Required: out stays 1, votes stays 3, pass_cnt unchanged.
- Saturation (CNT_W = 4):
  - Stimulus: hold abc = 110 with en = 1 for 20 clocks.
  - Required: pass_cnt climbs 1..15, then stays 15. out = 1 and dissent = 001 throughout.
- Reset mid-operation:
  - Stimulus: with pass_cnt = 15 and out = 1, assert rst_n = 0 for one edge while en = 1 and abc = 111.
  - Required: all outputs cleared after that edge; the next enabled edge gives out = 1, pass_cnt = 1.
- Synchronous reset check:
  - Stimulus: pulse rst_n low between clock edges only, never across a rising edge.
  - Required: no output change.
- Glitch immunity:
  - Stimulus: toggle a, b, c between edges; settle at abc = 011 before the edge.
  - Required: out = 1, votes = 2, dissent = 100.
